// File: rtl/zero_share_scheduler_pkg.sv
// Shared constants and helpers for masked-zero sharing generation.
package zero_share_scheduler_pkg;

  // Default width of the starvation counter
  localparam int STARVE_CNT_WIDTH = 8;

  // Widest sharing the expansion helper can produce
  localparam int MAX_SHARES       = 5;
  localparam int MAX_BIT_WIDTH    = 32;
  localparam int SHARE_WORD_WIDTH = MAX_SHARES * MAX_BIT_WIDTH;

  typedef logic [SHARE_WORD_WIDTH-1:0] share_word_t;

  // Number of raw random words needed to build one sharing of zero
  function automatic int num_zero_random(input int num_shares);
    case (num_shares)
      2:       return 1;
      3:       return 2;
      4:       return 4;
      5:       return 5;
      default: return 1;
    endcase
  endfunction

  // Expand packed random words r[0..] (r0 in the LSBs) into num_shares
  // shares of bit_width bits each whose XOR is zero. Share 0 sits in the LSBs.
  function automatic share_word_t zero_share_expand(input int          num_shares,
                                                    input int          bit_width,
                                                    input share_word_t word);
    share_word_t mask;
    share_word_t r0;
    share_word_t r1;
    share_word_t ri;
    share_word_t rn;
    share_word_t share;
    share_word_t result;
    mask   = (share_word_t'(1) << bit_width) - share_word_t'(1);
    r0     = word & mask;
    r1     = (word >> bit_width) & mask;
    result = '0;
    for (int i = 0; i < MAX_SHARES; i++) begin
      if (i < num_shares) begin
        ri = (word >> (i * bit_width)) & mask;
        rn = (word >> (((i + 1) % num_shares) * bit_width)) & mask;
        case (num_shares)
          2:       share = r0;
          3:       share = (i == 0) ? r0 : ((i == 1) ? r1 : (r0 ^ r1));
          default: share = ri ^ rn;
        endcase
        result = result | (share << (i * bit_width));
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/zero_share_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the priority
// pointer (cyclic upward search). The pointer is kept one-hot so that
// the "at or after" mask and the advance-by-one are plain bit operations.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] pointer_reg;
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] pick;

  // Pick the lowest request at or above the pointer, else wrap to the lowest overall
  always_comb begin
    upper_mask = ~(pointer_reg - NUM_REQ'(1));
    upper_req  = request & upper_mask;
    pick       = (|upper_req) ? upper_req : request;
    grant      = enable ? (pick & (~pick + NUM_REQ'(1))) : '0;
  end

  // Pointer moves to the position just above the granted index
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      pointer_reg <= NUM_REQ'(1);
    end else if (|grant) begin
      pointer_reg <= {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};
    end
  end

endmodule

// File: rtl/zero_share_scheduler.sv
// Buffers PRNG words in a small FIFO, grants one word per cycle to a
// round-robin selected requester and delivers it expanded into a
// registered sharing of zero, tagged with the one-hot grant.
module zero_share_scheduler
  import zero_share_scheduler_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 2,
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = STARVE_CNT_WIDTH
) (
  input  logic                                            in_clock,
  input  logic                                            in_reset,
  input  logic [num_zero_random(NUM_SHARES)*BIT_WIDTH-1:0] in_random,
  input  logic                                            in_random_valid,
  output logic                                            out_random_ready,
  input  logic [NUM_REQ-1:0]                              in_request,
  output logic [NUM_REQ-1:0]                              out_grant,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]                 out_zero,
  output logic                                            out_zero_valid,
  output logic [CNT_WIDTH-1:0]                            out_starve_count
);

  localparam int NUM_NEEDED = num_zero_random(NUM_SHARES);
  localparam int RAND_W     = NUM_NEEDED * BIT_WIDTH;
  localparam int ZERO_W     = NUM_SHARES * BIT_WIDTH;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int OCC_W      = $clog2(DEPTH + 1);

  // Reject unsupported configurations at elaboration
  if (NUM_SHARES < 2 || NUM_SHARES > MAX_SHARES) begin : g_bad_shares
    $fatal(1, "zero_share_scheduler: NUM_SHARES must be 2..5");
  end
  if (BIT_WIDTH < 1 || BIT_WIDTH > MAX_BIT_WIDTH) begin : g_bad_width
    $fatal(1, "zero_share_scheduler: BIT_WIDTH must be 1..32");
  end
  if (NUM_REQ < 2) begin : g_bad_req
    $fatal(1, "zero_share_scheduler: NUM_REQ must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "zero_share_scheduler: DEPTH must be a power of two, at least 2");
  end

  logic [RAND_W-1:0]    fifo_mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_reg;
  logic [ADDR_W-1:0]    rd_ptr_reg;
  logic [OCC_W-1:0]     occupancy_reg;
  logic [CNT_WIDTH-1:0] starve_count_reg;
  logic [NUM_REQ-1:0]   grant_reg;
  logic [ZERO_W-1:0]    zero_reg;
  logic                 zero_valid_reg;

  logic                 fifo_empty;
  logic                 fifo_nonempty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 starved;
  logic [NUM_REQ-1:0]   grant;
  logic [ZERO_W-1:0]    zero_next;

  // FIFO status, handshake decode and expansion of the head word
  always_comb begin
    fifo_empty    = (occupancy_reg == '0);
    fifo_nonempty = ~fifo_empty;
    fifo_full     = (occupancy_reg == OCC_W'(DEPTH));
    push          = in_random_valid & ~fifo_full;
    pop           = |grant;
    starved       = (|in_request) & fifo_empty;
    zero_next     = ZERO_W'(zero_share_expand(NUM_SHARES, BIT_WIDTH,
                                              share_word_t'(fifo_mem[rd_ptr_reg])));
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .request  (in_request),
    .enable   (fifo_nonempty),
    .grant    (grant)
  );

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge in_clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_random;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); occupancy decides full/empty
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occupancy_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy_reg <= occupancy_reg + OCC_W'(1);
        2'b01:   occupancy_reg <= occupancy_reg - OCC_W'(1);
        default: occupancy_reg <= occupancy_reg;
      endcase
    end
  end

  // Saturating count of cycles where someone asked but nothing was buffered
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      starve_count_reg <= '0;
    end else if (starved && (starve_count_reg != '1)) begin
      starve_count_reg <= starve_count_reg + CNT_WIDTH'(1);
    end
  end

  // Output stage: grant and valid every cycle, sharing only updates on a grant
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      grant_reg      <= '0;
      zero_reg       <= '0;
      zero_valid_reg <= 1'b0;
    end else begin
      grant_reg      <= grant;
      zero_valid_reg <= pop;
      if (pop) begin
        zero_reg <= zero_next;
      end
    end
  end

  assign out_random_ready = ~fifo_full;
  assign out_grant        = grant_reg;
  assign out_zero         = zero_reg;
  assign out_zero_valid   = zero_valid_reg;
  assign out_starve_count = starve_count_reg;

endmodule

// File: tb/tb_zero_share_scheduler.sv
// Directed bench: three scheduler instances (2, 3 and 5 shares) sharing
// one clock and reset, checked against hand-computed vectors.
module tb_zero_share_scheduler;

  logic clk;
  logic rst_n;

  // Instance A: 2 shares, depth 2
  logic [1:0] a_random;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] a_req;
  logic [3:0] a_grant;
  logic [3:0] a_zero;
  logic       a_zero_valid;
  logic [7:0] a_starve;

  // Instance B: 3 shares, depth 4
  logic [3:0] b_random;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] b_req;
  logic [3:0] b_grant;
  logic [5:0] b_zero;
  logic       b_zero_valid;
  logic [7:0] b_starve;

  // Instance C: 5 shares, depth 2
  logic [9:0] c_random;
  logic       c_valid;
  logic       c_ready;
  logic [3:0] c_req;
  logic [3:0] c_grant;
  logic [9:0] c_zero;
  logic       c_zero_valid;
  logic [7:0] c_starve;

  int checks_total;
  int checks_passed;

  zero_share_scheduler #(
    .NUM_SHARES(2), .BIT_WIDTH(2), .NUM_REQ(4), .DEPTH(2), .CNT_WIDTH(8)
  ) dut_a (
    .in_clock(clk), .in_reset(rst_n),
    .in_random(a_random), .in_random_valid(a_valid), .out_random_ready(a_ready),
    .in_request(a_req), .out_grant(a_grant), .out_zero(a_zero),
    .out_zero_valid(a_zero_valid), .out_starve_count(a_starve)
  );

  zero_share_scheduler #(
    .NUM_SHARES(3), .BIT_WIDTH(2), .NUM_REQ(4), .DEPTH(4), .CNT_WIDTH(8)
  ) dut_b (
    .in_clock(clk), .in_reset(rst_n),
    .in_random(b_random), .in_random_valid(b_valid), .out_random_ready(b_ready),
    .in_request(b_req), .out_grant(b_grant), .out_zero(b_zero),
    .out_zero_valid(b_zero_valid), .out_starve_count(b_starve)
  );

  zero_share_scheduler #(
    .NUM_SHARES(5), .BIT_WIDTH(2), .NUM_REQ(4), .DEPTH(2), .CNT_WIDTH(8)
  ) dut_c (
    .in_clock(clk), .in_reset(rst_n),
    .in_random(c_random), .in_random_valid(c_valid), .out_random_ready(c_ready),
    .in_request(c_req), .out_grant(c_grant), .out_zero(c_zero),
    .out_zero_valid(c_zero_valid), .out_starve_count(c_starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed !== expected) begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end else begin
      checks_passed++;
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_random = '0; a_valid = 1'b0; a_req = '0;
    b_random = '0; b_valid = 1'b0; b_req = '0;
    c_random = '0; c_valid = 1'b0; c_req = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  logic       saw_valid;
  logic [1:0] xor_acc;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset values
    check_value("rst_valid", a_zero_valid, 0);
    check_value("rst_grant", a_grant, 0);
    check_value("rst_zero", a_zero, 0);
    check_value("rst_starve", a_starve, 0);
    check_value("rst_ready", a_ready, 1);

    // Basic output: push 10 with request 0001 held; output 2 cycles later
    a_random = 2'b10; a_valid = 1'b1; a_req = 4'b0001;
    tick();
    a_valid = 1'b0;
    check_value("basic_no_bypass", a_zero_valid, 0);
    check_value("basic_starve_1", a_starve, 1);
    tick();
    check_value("basic_valid", a_zero_valid, 1);
    check_value("basic_grant", a_grant, 4'b0001);
    check_value("basic_zero", a_zero, 4'b1010);
    check_value("basic_starve", a_starve, 1);
    a_req = 4'b0000;
    tick();
    check_value("idle_valid", a_zero_valid, 0);
    check_value("idle_grant", a_grant, 0);
    check_value("idle_zero_hold", a_zero, 4'b1010);

    // Round-robin rotation with the FIFO starting full
    apply_reset();
    a_random = 2'b01; a_valid = 1'b1;
    tick();
    a_random = 2'b10;
    tick();
    check_value("full_ready", a_ready, 0);
    a_random = 2'b00; a_req = 4'b1011;   // must not be written: FIFO is full
    tick();
    check_value("rr_grant0", a_grant, 4'b0001);
    check_value("rr_zero0", a_zero, 4'b0101);
    check_value("full_pop_ready", a_ready, 1);
    a_random = 2'b11;
    tick();
    check_value("rr_grant1", a_grant, 4'b0010);
    check_value("rr_zero1", a_zero, 4'b1010);
    check_value("occ1_ready", a_ready, 1);
    a_random = 2'b10;
    tick();
    check_value("rr_grant2", a_grant, 4'b1000);
    check_value("rr_zero2", a_zero, 4'b1111);
    a_random = 2'b01;
    tick();
    check_value("rr_grant3", a_grant, 4'b0001);
    check_value("rr_zero3", a_zero, 4'b1010);
    a_valid = 1'b0;
    tick();
    check_value("occ1_last_grant", a_grant, 4'b0010);
    check_value("occ1_last_zero", a_zero, 4'b0101);
    tick();
    check_value("drained_valid", a_zero_valid, 0);
    a_req = 4'b0000;

    // Starvation: 300 cycles of request with nothing buffered
    apply_reset();
    a_req = 4'b0100;
    saw_valid = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick();
      saw_valid = saw_valid | a_zero_valid;
    end
    check_value("starve_254", a_starve, 254);
    tick();
    saw_valid = saw_valid | a_zero_valid;
    check_value("starve_255", a_starve, 255);
    for (int i = 0; i < 45; i++) begin
      tick();
      saw_valid = saw_valid | a_zero_valid;
    end
    check_value("starve_saturated", a_starve, 255);
    check_value("starve_no_valid", saw_valid, 0);
    a_req = 4'b0000;

    // Three shares: r0=01, r1=11 -> shares 01, 11, 10
    apply_reset();
    b_random = 4'b1101; b_valid = 1'b1; b_req = 4'b0001;
    tick();
    b_valid = 1'b0;
    tick();
    check_value("ns3_valid", b_zero_valid, 1);
    check_value("ns3_grant", b_grant, 4'b0001);
    check_value("ns3_zero", b_zero, 6'b101101);
    b_req = 4'b0000;

    // Five shares: directed word, then XOR-of-shares over several words
    c_random = 10'b1000111001; c_valid = 1'b1; c_req = 4'b0001;
    tick();
    c_valid = 1'b0;
    tick();
    check_value("ns5_zero", c_zero, 10'b1110110111);
    for (int w = 0; w < 6; w++) begin
      c_random = 10'($urandom);
      c_valid  = 1'b1;
      tick();
      c_valid = 1'b0;
      tick();
      check_value("ns5_valid", c_zero_valid, 1);
      xor_acc = '0;
      for (int s = 0; s < 5; s++) begin
        xor_acc = xor_acc ^ c_zero[s*2 +: 2];
      end
      check_value("ns5_xor", xor_acc, 0);
    end
    c_req = 4'b0000;

    // Reset mid-operation on B with occupancy 2 and a valid output
    b_random = 4'b0001; b_valid = 1'b1;
    tick();
    b_random = 4'b0010;
    tick();
    b_random = 4'b0011; b_req = 4'b0001;
    tick();
    b_valid = 1'b0; b_req = 4'b1011;
    check_value("mid_valid", b_zero_valid, 1);
    check_value("mid_zero", b_zero, 6'b010001);
    #3;
    rst_n = 1'b0;
    #1;
    check_value("async_valid", b_zero_valid, 0);
    check_value("async_grant", b_grant, 0);
    check_value("async_zero", b_zero, 0);
    check_value("async_starve", b_starve, 0);
    check_value("async_ready", b_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_value("post_rst_empty", b_zero_valid, 0);
    b_random = 4'b1110; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    tick();
    check_value("post_rst_grant", b_grant, 4'b0001);
    check_value("post_rst_zero", b_zero, 6'b011110);
    check_value("post_rst_starve", b_starve, 2);
    b_req = 4'b0000;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/zero_share_scheduler.md
# zero_share_scheduler

Arbitrated distributor of fresh masked-zero sharings for the S-box pipeline. It buffers raw randomness from the PRNG stream in a small FIFO and grants one entry per cycle to one of NUM_REQ requesting gadgets using round-robin arbitration. It expands the granted entry into a NUM_SHARES-share sharing of zero and delivers it registered, tagged with the one-hot grant. It also counts starvation cycles so the PRNG rate can be checked.

## Interface
- NUM_SHARES, 2, number of shares; supported values are 2–5, any other value is a `$fatal` at elaboration
- BIT_WIDTH, 2, bits per share
- NUM_REQ, 4, number of requesters; minimum 2
- DEPTH, 2, FIFO entries; power of two, at least 2
- CNT_WIDTH, 8, starvation counter width
- in_clock  input  1  single clock, rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_random  input  NUM_NEEDED*BIT_WIDTH  raw randomness word; NUM_NEEDED = num_zero_random(NUM_SHARES)
- in_random_valid  input  1  in_random is valid
- out_random_ready  output  1  FIFO accepts a word; equals not-full
- in_request  input  NUM_REQ  level request per consumer
- out_grant  output  NUM_REQ  registered one-hot grant that accompanies out_zero
- out_zero  output  NUM_SHARES*BIT_WIDTH  registered sharing of zero
- out_zero_valid  output  1  out_zero and out_grant are valid this cycle
- out_starve_count  output  CNT_WIDTH  saturating count of starved cycles

## Operation
- **Push:** a word is written to the FIFO when in_random_valid and out_random_ready are both high.
- **Pop/grant:** occurs when the FIFO is not empty and in_request is non-zero. The granted index is the first set request bit at or after the priority pointer, searching cyclically upward. The head entry is popped in the same cycle.
- **Priority pointer:** after a grant to index g, the pointer becomes (g+1) mod NUM_REQ. It is unchanged when no grant occurs.
- **Sharing of the popped word r[0..NUM_NEEDED-1]:**
  - NUM_SHARES=2: shares are r0, r0.
  - NUM_SHARES=3: shares are r0, r1, r0^r1.
  - NUM_SHARES=4 or 5: share i = r[i] ^ r[(i+1) mod NUM_SHARES].
  - The XOR of all shares is always 0.
- **Starvation:** a cycle with in_request non-zero and the FIFO empty increments out_starve_count. The counter saturates at all-ones and is cleared only by reset.
- **Simultaneous push and pop:**
  - FIFO not empty: both happen and the occupancy is unchanged.
  - FIFO full: ready is low, so only the pop happens; ready rises the next cycle.
  - FIFO empty: there is no bypass. The pushed word becomes grantable the following cycle, and the cycle counts as starved if a request is present.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH. A separate occupancy counter (0..DEPTH) determines full and empty.
- **Reset:** asserting reset mid-operation discards all FIFO contents and any output in flight.
- **Reset values:**
  - out_zero_valid=0, out_grant=0, out_zero=0, out_starve_count=0.
  - out_random_ready=1 once reset is released.
  - Priority pointer=0; FIFO empty.

## Timing
- Grant decision is combinational on in_request, the occupancy and the pointer. out_grant, out_zero and out_zero_valid are registered, so they are valid exactly 1 cycle after the request cycle.
- Consumers must hold in_request until they see their out_grant bit, then drop it in that same cycle if they are done. A request still high in the grant cycle counts as a new request.
- Push-to-earliest-output latency is 2 cycles.
- Throughput is 1 sharing per cycle while the FIFO is non-empty.
- In a cycle with no grant, out_zero_valid=0, out_grant=0 and out_zero holds its previous value.
- out_random_ready is registered-derived (from occupancy) and carries no combinational path from the inputs.

## Structure
- In aes128_package:
  - Keep num_zero_random.
  - Add a function zero_share_expand(NUM_SHARES, word) so other gadgets produce the same sharing.
  - Add a constant for the starvation counter width.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: request vector, enable, in_clock, in_reset.
  - Outputs: one-hot grant.
  - Owns the priority pointer.
- FIFO storage, occupancy and starvation counter live in the top level. The output stage uses the existing register module.

## Test plan
- **Reset and basic output:** reset, then push word 2'b10 with request 4'b0001 held. Expect out_grant=0001 and out_zero={2'b10,2'b10} 2 cycles after the push, with out_starve_count=1.
- **Round-robin rotation:** fill the FIFO (DEPTH=2 → ready=0), then hold in_request=4'b1011 with continuous pushes. Expect grant order 0001, 0010, 1000, 0001.
- **Starvation count:** hold request 4'b0100 with no pushes for 300 cycles at CNT_WIDTH=8. Expect out_starve_count=255 (saturated) and out_zero_valid=0 throughout.
- **Push/pop when full:**
  - With the FIFO full, drive valid and request together: expect no write that cycle and ready=1 the next cycle.
  - With the FIFO at occupancy 1, push and pop in the same cycle: expect occupancy to stay at 1.
- **Zero sharing, NUM_SHARES=3:** push r0=01, r1=11. Expect shares 01, 11, 10.
- **Zero sharing, NUM_SHARES=5:** for random words, check that the XOR of all shares is 0.
- **Reset mid-operation:** assert reset with occupancy=2 and out_zero_valid=1. Expect all outputs to clear immediately (asynchronously) and the first grant after release to go to requester 0.
